// File: rtl/vector_memory_port.sv
// Memory-stage vector access sequencer: splits a 128-bit vector load/store
// into eight 16-bit data-memory accesses while stalling the pipeline.
module vector_memory_port (
  input  logic         clk,
  input  logic         reset,
  input  logic         vector_store_memory,
  input  logic         vector_load_memory,
  input  logic [7:0]   vector_address_data_memory,
  input  logic [127:0] vector_data_memory,
  input  logic [15:0]  mem_read_data,
  output logic [7:0]   mem_address,
  output logic [15:0]  mem_write_data,
  output logic         mem_write_enable,
  output logic         mem_read_enable,
  output logic         stall_pipeline,
  output logic [127:0] vector_load_data,
  output logic         vector_load_valid
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_STORE      = 2'd1;
  localparam logic [1:0] S_LOAD       = 2'd2;
  localparam logic [1:0] S_LOAD_DRAIN = 2'd3;

  logic [1:0]   r_state;
  logic [2:0]   r_lane;
  logic [7:0]   r_base;
  logic [127:0] r_buf;
  logic [127:0] r_load;
  logic         r_valid;

  logic [7:0]   w_addr;
  logic [2:0]   w_prev_lane;

  assign w_addr      = r_base + {5'b0, r_lane};
  assign w_prev_lane = r_lane - 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lane  <= '0;
      r_base  <= '0;
      r_buf   <= '0;
      r_load  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Store has priority when both strobes are presented.
          if (vector_store_memory) begin
            r_base  <= vector_address_data_memory;
            r_buf   <= vector_data_memory;
            r_lane  <= '0;
            r_state <= S_STORE;
          end else if (vector_load_memory) begin
            r_base  <= vector_address_data_memory;
            r_lane  <= '0;
            r_state <= S_LOAD;
          end
        end
        S_STORE: begin
          r_lane <= r_lane + 3'd1;
          if (r_lane == 3'd7) r_state <= S_IDLE;
        end
        S_LOAD: begin
          // Read data trails the issued address by one cycle.
          if (r_lane != 3'd0) r_load[{w_prev_lane, 4'b0} +: 16] <= mem_read_data;
          r_lane <= r_lane + 3'd1;
          if (r_lane == 3'd7) r_state <= S_LOAD_DRAIN;
        end
        default: begin
          r_load[127:112] <= mem_read_data;
          r_valid         <= 1'b1;
          r_state         <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    stall_pipeline   = 1'b0;
    case (r_state)
      S_IDLE: stall_pipeline = vector_store_memory | vector_load_memory;
      S_STORE: begin
        mem_address      = w_addr;
        mem_write_data   = r_buf[{r_lane, 4'b0} +: 16];
        mem_write_enable = 1'b1;
        stall_pipeline   = (r_lane != 3'd7);
      end
      S_LOAD: begin
        mem_address     = w_addr;
        mem_read_enable = 1'b1;
        stall_pipeline  = 1'b1;
      end
      default: ;
    endcase
  end

  assign vector_load_data  = r_load;
  assign vector_load_valid = r_valid;

endmodule

// File: tb/tb_vector_memory_port.sv
// Directed self-checking bench for vector_memory_port with a 1-cycle RAM model
// and a pipeline model that holds the EX/MEM request while stalled.
module tb_vector_memory_port;

  logic         clk = 1'b0;
  logic         reset;
  logic         vector_store_memory;
  logic         vector_load_memory;
  logic [7:0]   vector_address_data_memory;
  logic [127:0] vector_data_memory;
  logic [15:0]  mem_read_data;
  logic [7:0]   mem_address;
  logic [15:0]  mem_write_data;
  logic         mem_write_enable;
  logic         mem_read_enable;
  logic         stall_pipeline;
  logic [127:0] vector_load_data;
  logic         vector_load_valid;

  int checks = 0;
  int failures = 0;

  // Per-run logs
  int          wr_n, rd_n, st_n, v_n, v_c;
  logic [7:0]  wr_a [0:31];
  logic [15:0] wr_d [0:31];
  int          wr_c [0:31];
  logic [7:0]  rd_a [0:31];
  int          rd_c [0:31];
  logic        st   [0:63];
  logic        zr   [0:63];
  logic [127:0] vdata;

  vector_memory_port dut (
    .clk                        (clk),
    .reset                      (reset),
    .vector_store_memory        (vector_store_memory),
    .vector_load_memory         (vector_load_memory),
    .vector_address_data_memory (vector_address_data_memory),
    .vector_data_memory         (vector_data_memory),
    .mem_read_data              (mem_read_data),
    .mem_address                (mem_address),
    .mem_write_data             (mem_write_data),
    .mem_write_enable           (mem_write_enable),
    .mem_read_enable            (mem_read_enable),
    .stall_pipeline             (stall_pipeline),
    .vector_load_data           (vector_load_data),
    .vector_load_valid          (vector_load_valid)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: returns 0xA000+addr one cycle after a read strobe.
  always @(posedge clk) begin
    if (mem_read_enable) mem_read_data <= 16'hA000 + {8'h00, mem_address};
  end

  function automatic logic [127:0] lanes(input logic [15:0] b);
    logic [127:0] v;
    for (int unsigned i = 0; i < 8; i++) v[16*i +: 16] = b + 16'(i);
    return v;
  endfunction

  task automatic present(input logic s, input logic l, input logic [7:0] b,
                         input logic [127:0] d);
    vector_store_memory        = s;
    vector_load_memory         = l;
    vector_address_data_memory = b;
    vector_data_memory         = d;
  endtask

  // Cycle 0 is the first cycle instr0 is presented; a second instruction
  // replaces it once the pipeline sees stall low at a clock edge.
  task automatic run(input logic s0, input logic l0, input logic [7:0] b0,
                     input logic [127:0] d0, input logic has1, input logic s1,
                     input logic l1, input logic [7:0] b1, input logic [127:0] d1,
                     input int ncyc, input int rst_cyc);
    int idx;
    logic sst;
    wr_n = 0; rd_n = 0; st_n = 0; v_n = 0; v_c = -1; vdata = '0;
    for (int i = 0; i < 64; i++) begin st[i] = 1'b0; zr[i] = 1'b0; end
    @(posedge clk); #1;
    present(s0, l0, b0, d0);
    idx = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == rst_cyc) begin
        reset = 1'b1;
        present(1'b0, 1'b0, 8'h00, '0);
        idx = 2;
      end
      @(negedge clk);
      sst   = stall_pipeline;
      st[c] = sst;
      if (sst) st_n++;
      zr[c] = (mem_address == 8'h00) && (mem_write_data == 16'h0000) &&
              !mem_write_enable && !mem_read_enable && !stall_pipeline &&
              !vector_load_valid;
      if (mem_write_enable && wr_n < 32) begin
        wr_a[wr_n] = mem_address; wr_d[wr_n] = mem_write_data; wr_c[wr_n] = c; wr_n++;
      end
      if (mem_read_enable && rd_n < 32) begin
        rd_a[rd_n] = mem_address; rd_c[rd_n] = c; rd_n++;
      end
      if (vector_load_valid) begin v_n++; v_c = c; vdata = vector_load_data; end
      @(posedge clk); #1;
      reset = 1'b0;
      if (!sst && idx < 2) begin
        idx++;
        if (idx == 1 && has1) present(s1, l1, b1, d1);
        else begin present(1'b0, 1'b0, 8'h00, '0); idx = 2; end
      end
    end
    present(1'b0, 1'b0, 8'h00, '0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    present(1'b0, 1'b0, 8'h00, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_address, mem_write_data, mem_write_enable, mem_read_enable,
         stall_pipeline, vector_load_valid} !== '0 || vector_load_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs: addr=%h wd=%h we=%b re=%b stall=%b v=%b vd=%h",
               mem_address, mem_write_data, mem_write_enable, mem_read_enable,
               stall_pipeline, vector_load_valid, vector_load_data);
    end
  endtask

  task automatic test_store;
    int bad;
    run(1'b1, 1'b0, 8'h10, lanes(16'h0000), 1'b0, 1'b0, 1'b0, 8'h00, '0, 12, -1);
    checks++;
    if (wr_n !== 8) begin failures++; $display("FAIL store_count: got %0d want 8", wr_n); end
    bad = 0;
    for (int i = 0; i < 8 && i < wr_n; i++)
      if (wr_a[i] !== 8'(8'h10 + i) || wr_d[i] !== 16'(i) || wr_c[i] !== i + 1) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL store_writes: %0d bad of 8 (first addr=%h data=%h cyc=%0d)", bad, wr_a[0], wr_d[0], wr_c[0]); end
    checks++;
    if (st_n !== 8 || st[7] !== 1'b1 || st[8] !== 1'b0) begin
      failures++; $display("FAIL store_stall: cycles=%0d st7=%b st8=%b want 8/1/0", st_n, st[7], st[8]);
    end
    checks++;
    if (rd_n !== 0) begin failures++; $display("FAIL store_no_reads: got %0d want 0", rd_n); end
  endtask

  task automatic test_load;
    int bad;
    run(1'b0, 1'b1, 8'h20, '0, 1'b0, 1'b0, 1'b0, 8'h00, '0, 14, -1);
    checks++;
    if (vdata !== 128'hA027_A026_A025_A024_A023_A022_A021_A020) begin
      failures++; $display("FAIL load_data: got %h want a027..a020", vdata);
    end
    checks++;
    if (v_n !== 1 || v_c !== 10) begin failures++; $display("FAIL load_valid: pulses=%0d cyc=%0d want 1 at 10", v_n, v_c); end
    checks++;
    if (st_n !== 9 || st[8] !== 1'b1 || st[9] !== 1'b0) begin
      failures++; $display("FAIL load_stall: cycles=%0d st8=%b st9=%b want 9/1/0", st_n, st[8], st[9]);
    end
    bad = 0;
    for (int i = 0; i < 8 && i < rd_n; i++)
      if (rd_a[i] !== 8'(8'h20 + i) || rd_c[i] !== i + 1) bad++;
    checks++;
    if (rd_n !== 8 || bad != 0 || wr_n !== 0) begin
      failures++; $display("FAIL load_reads: n=%0d bad=%0d writes=%0d want 8/0/0", rd_n, bad, wr_n);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_a [0:7];
    int bad;
    exp_a = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
    run(1'b1, 1'b0, 8'hFC, lanes(16'h5550), 1'b0, 1'b0, 1'b0, 8'h00, '0, 12, -1);
    bad = 0;
    for (int i = 0; i < 8 && i < wr_n; i++)
      if (wr_a[i] !== exp_a[i] || wr_d[i] !== 16'(16'h5550 + i)) bad++;
    checks++;
    if (wr_n !== 8 || bad != 0) begin
      failures++; $display("FAIL wrap_addr: n=%0d bad=%0d a4=%h want 8/0/00", wr_n, bad, wr_a[4]);
    end
  endtask

  task automatic test_both;
    run(1'b1, 1'b1, 8'h30, lanes(16'h7000), 1'b0, 1'b0, 1'b0, 8'h00, '0, 14, -1);
    checks++;
    if (wr_n !== 8 || rd_n !== 0) begin
      failures++; $display("FAIL both_store_wins: writes=%0d reads=%0d want 8/0", wr_n, rd_n);
    end
    checks++;
    if (v_n !== 0) begin failures++; $display("FAIL both_no_valid: pulses=%0d want 0", v_n); end
  endtask

  task automatic test_reset_mid;
    int bad;
    // Reset driven in cycle 3 takes effect at the edge opening cycle 4.
    run(1'b1, 1'b0, 8'h40, lanes(16'hB000), 1'b0, 1'b0, 1'b0, 8'h00, '0, 8, 3);
    bad = 0;
    for (int i = 0; i < 3 && i < wr_n; i++)
      if (wr_a[i] !== 8'(8'h40 + i) || wr_d[i] !== 16'(16'hB000 + i)) bad++;
    checks++;
    if (wr_n !== 3 || bad != 0) begin
      failures++; $display("FAIL reset_mid_writes: n=%0d bad=%0d want 3/0", wr_n, bad);
    end
    checks++;
    if (zr[4] !== 1'b1 || zr[5] !== 1'b1) begin
      failures++; $display("FAIL reset_mid_idle: zero4=%b zero5=%b want 1/1", zr[4], zr[5]);
    end
    run(1'b1, 1'b0, 8'h50, lanes(16'hC000), 1'b0, 1'b0, 1'b0, 8'h00, '0, 12, -1);
    checks++;
    if (wr_n !== 8 || wr_a[0] !== 8'h50 || wr_d[0] !== 16'hC000 || wr_c[0] !== 1 ||
        wr_a[7] !== 8'h57 || wr_d[7] !== 16'hC007) begin
      failures++; $display("FAIL reset_mid_restart: n=%0d a0=%h d0=%h c0=%0d a7=%h want 8/50/c000/1/57",
                           wr_n, wr_a[0], wr_d[0], wr_c[0], wr_a[7]);
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    run(1'b0, 1'b1, 8'h30, '0, 1'b1, 1'b1, 1'b0, 8'h60, lanes(16'h1110), 24, -1);
    checks++;
    if (vdata !== 128'hA037_A036_A035_A034_A033_A032_A031_A030 || v_n !== 1 || v_c !== 10) begin
      failures++; $display("FAIL b2b_load: data=%h pulses=%0d cyc=%0d want a037..a030/1/10", vdata, v_n, v_c);
    end
    checks++;
    if (rd_n !== 8 || rd_c[7] !== 8 || st[9] !== 1'b0 || st[10] !== 1'b1) begin
      failures++; $display("FAIL b2b_handoff: reads=%0d last=%0d st9=%b st10=%b want 8/8/0/1",
                           rd_n, rd_c[7], st[9], st[10]);
    end
    bad = 0;
    for (int i = 0; i < 8 && i < wr_n; i++)
      if (wr_a[i] !== 8'(8'h60 + i) || wr_d[i] !== 16'(16'h1110 + i) || wr_c[i] !== i + 11) bad++;
    checks++;
    if (wr_n !== 8 || bad != 0) begin
      failures++; $display("FAIL b2b_store: n=%0d bad=%0d first_cyc=%0d want 8/0/11", wr_n, bad, wr_c[0]);
    end
    checks++;
    if (st_n !== 17) begin failures++; $display("FAIL b2b_stall_total: got %0d want 17", st_n); end
  endtask

  initial begin
    reset = 1'b0;
    present(1'b0, 1'b0, 8'h00, '0);
    test_reset;
    test_store;
    test_load;
    test_wrap;
    test_both;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
